// File: rtl/dwc_retry_ctrl.sv
// Retry/escalation sequencer for a duplicated-with-comparison datapath with registered outputs.
// Build option DWC_RETRY_CTRL_RETRY_EN enables bounded re-execution; without it the first mismatch is fatal.
//
// state   | meaning
// IDLE    | ready for an operand
// WAIT    | operand driven, counting down datapath latency
// CHECK   | one cycle: sample result and comparator error
// RESP    | checked result presented until consumed
// FATAL   | retries exhausted, sticky until cleared
module dwc_retry_ctrl #(
  parameter int WIDTH     = 2,
  parameter int OUT_WIDTH = 1,
  parameter int LATENCY   = 1,
  parameter int MAX_RETRY = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 port_req_valid,
  output logic                 port_req_ready,
  input  logic [WIDTH-1:0]     port_req_data,
  output logic [WIDTH-1:0]     port_dp_in,
  input  logic [OUT_WIDTH-1:0] port_dp_out,
  input  logic                 port_dwc_error,
  output logic                 port_rsp_valid,
  input  logic                 port_rsp_ready,
  output logic [OUT_WIDTH-1:0] port_rsp_data,
  output logic [2:0]           port_rsp_retries,
  output logic                 port_fatal,
  input  logic                 port_fatal_clr,
  output logic [CNT_WIDTH-1:0] port_err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_RESP,
    S_FATAL
  } state_t;

`ifdef DWC_RETRY_CTRL_RETRY_EN
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);
`else
  // Retries disabled: the limit collapses to zero whatever MAX_RETRY says.
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY) & 3'd0;
`endif
  localparam logic [3:0]           LAT_LOAD = 4'(LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               state;
  logic [WIDTH-1:0]     operand;
  logic [2:0]           retry_cnt;
  logic [3:0]           lat_cnt;
  logic [OUT_WIDTH-1:0] rsp_data;
  logic                 rsp_valid;
  logic                 req_ready;
  logic                 fatal;
  logic [CNT_WIDTH-1:0] err_count;

`ifdef DWC_RETRY_CTRL_RETRY_EN
  logic [2:0] rsp_retries;
  assign port_rsp_retries = rsp_retries;
`else
  assign port_rsp_retries = 3'd0;
`endif

  assign port_dp_in     = operand;
  assign port_req_ready = req_ready;
  assign port_rsp_valid = rsp_valid;
  assign port_rsp_data  = rsp_data;
  assign port_fatal     = fatal;
  assign port_err_count = err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      operand   <= '0;
      retry_cnt <= '0;
      lat_cnt   <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
      fatal     <= 1'b0;
      err_count <= '0;
`ifdef DWC_RETRY_CTRL_RETRY_EN
      rsp_retries <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (port_req_valid) begin
            operand   <= port_req_data;
            retry_cnt <= '0;
            lat_cnt   <= LAT_LOAD;
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt <= 4'd1) state <= S_CHECK;
        end
        S_CHECK: begin
          if (!port_dwc_error) begin
            rsp_data  <= port_dp_out;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
`ifdef DWC_RETRY_CTRL_RETRY_EN
            rsp_retries <= retry_cnt;
`endif
          end else begin
            if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
            // retry_cnt never exceeds the limit, so inequality means retries remain
            if (retry_cnt != RETRY_LIM) begin
              retry_cnt <= retry_cnt + 1'b1;
              lat_cnt   <= LAT_LOAD;
              state     <= S_WAIT;
            end else begin
              fatal <= 1'b1;
              state <= S_FATAL;
            end
          end
        end
        S_RESP: begin
          if (port_rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_FATAL: begin
          if (port_fatal_clr) begin
            fatal     <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          fatal     <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dwc_retry_ctrl.sv
// Bench for dwc_retry_ctrl: transaction-level reference model, directed scenarios, then random traffic.
module tb_dwc_retry_ctrl;
  localparam int W    = 2;
  localparam int OW   = 1;
  localparam int LAT  = 3;
  localparam int MAXR = 3;
  localparam int CW   = 4;
`ifdef DWC_RETRY_CTRL_RETRY_EN
  localparam int EFF = MAXR;
`else
  localparam int EFF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_data, dp_in;
  logic [OW-1:0] dp_out, rsp_data;
  logic          dwc_error, rsp_valid, rsp_ready, fatal, fatal_clr;
  logic [2:0]    rsp_retries;
  logic [CW-1:0] err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dwc_retry_ctrl #(.WIDTH(W), .OUT_WIDTH(OW), .LATENCY(LAT), .MAX_RETRY(MAXR), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .port_req_valid(req_valid), .port_req_ready(req_ready), .port_req_data(req_data),
    .port_dp_in(dp_in), .port_dp_out(dp_out), .port_dwc_error(dwc_error),
    .port_rsp_valid(rsp_valid), .port_rsp_ready(rsp_ready), .port_rsp_data(rsp_data),
    .port_rsp_retries(rsp_retries), .port_fatal(fatal), .port_fatal_clr(fatal_clr),
    .port_err_count(err_count)
  );

  // Reference model: a transaction is in flight, its k-th check lands on an absolute edge number.
  int          edge_n = 0;
  bit          m_busy, m_rv, m_fatal;
  int          m_k, m_check_edge, m_cnt, m_rret;
  logic [W-1:0]  m_op;
  logic [OW-1:0] m_rdata;

  task model_reset();
    m_busy = 0; m_rv = 0; m_fatal = 0;
    m_k = 0; m_check_edge = 0; m_cnt = 0; m_rret = 0;
    m_op = '0; m_rdata = '0;
  endtask

  task model_edge();
    edge_n++;
    if (rst_n) begin
      if (m_fatal) begin
        if (fatal_clr) m_fatal = 0;
      end else if (m_rv) begin
        if (rsp_ready) m_rv = 0;
      end else if (m_busy) begin
        if (edge_n == m_check_edge) begin
          if (!dwc_error) begin
            m_rv = 1; m_rdata = dp_out; m_rret = m_k; m_busy = 0;
          end else begin
            if (m_cnt < (2 ** CW) - 1) m_cnt++;
            if (m_k == EFF) begin
              m_fatal = 1; m_busy = 0;
            end else begin
              m_k++;
              m_check_edge += LAT + 1;
            end
          end
        end
      end else if (req_valid) begin
        m_busy = 1; m_op = req_data; m_k = 0; m_check_edge = edge_n + LAT + 1;
      end
    end
  endtask

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task compare();
    chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_rv && !m_fatal));
    chk("dp_in", 32'(dp_in), 32'(m_op));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_data", 32'(rsp_data), 32'(m_rdata));
    chk("rsp_retries", 32'(rsp_retries), 32'(m_rret));
    chk("fatal", 32'(fatal), 32'(m_fatal));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task idle_in();
    req_valid = 0; req_data = '0; rsp_ready = 0; fatal_clr = 0; dwc_error = 0; dp_out = '0;
  endtask

  task apply_reset();
    rst_n = 0;
    #1;
    model_reset();
    compare();
    cyc();
    rst_n = 1;
  endtask

  task accept(input logic [W-1:0] d);
    req_valid = 1; req_data = d;
    cyc();
    req_valid = 0;
  endtask

  int  n;
  bit  saw_rv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_in();
    model_reset();
    @(negedge clk);
    compare();
    chk("reset_ready_lit", 32'(req_ready), 32'd1);
    chk("reset_valid_lit", 32'(rsp_valid), 32'd0);
    rst_n = 1;
    cyc();

    // clean pass: response visible LAT+1 edges after accept
    accept(2'b11);
    dp_out = 1'b1;
    n = 0;
    while (!rsp_valid && n < 40) begin cyc(); n++; end
    chk("clean_latency_lit", 32'(n), 32'(LAT + 1));
    chk("clean_data_lit", 32'(rsp_data), 32'd1);
    chk("clean_retries_lit", 32'(rsp_retries), 32'd0);
    chk("clean_errcnt_lit", 32'(err_count), 32'd0);
    rsp_ready = 1; cyc(); idle_in();

    // single transient mismatch on the first check only
    apply_reset();
    accept(2'b10);
    n = 0;
    while (!rsp_valid && !fatal && n < 40) begin
      n++;
      dwc_error = (n == LAT + 1);
      dp_out = OW'($urandom);
      cyc();
    end
`ifdef DWC_RETRY_CTRL_RETRY_EN
    chk("transient_latency_lit", 32'(n), 32'(2 * (LAT + 1)));
    chk("transient_retries_lit", 32'(rsp_retries), 32'd1);
`else
    chk("transient_fatal_edge_lit", 32'(n), 32'(LAT + 1));
    chk("transient_fatal_lit", 32'(fatal), 32'd1);
`endif
    chk("transient_errcnt_lit", 32'(err_count), 32'd1);
    idle_in(); rsp_ready = 1; fatal_clr = 1; cyc(); idle_in();

    // exhaustion with error held high
    apply_reset();
    accept(2'b01);
    dwc_error = 1;
    n = 0; saw_rv = 0;
    while (!fatal && n < 100) begin cyc(); n++; if (rsp_valid) saw_rv = 1; end
    chk("exhaust_edge_lit", 32'(n), 32'((EFF + 1) * (LAT + 1)));
    chk("exhaust_errcnt_lit", 32'(err_count), 32'(EFF + 1));
    chk("exhaust_no_rsp_lit", 32'(saw_rv), 32'd0);
    req_valid = 1; req_data = 2'b11;
    repeat (3) begin cyc(); chk("fatal_ready_lit", 32'(req_ready), 32'd0); end
    req_valid = 0; fatal_clr = 1; cyc(); fatal_clr = 0;
    chk("fatal_clr_lit", 32'(fatal), 32'd0);
    chk("fatal_clr_ready_lit", 32'(req_ready), 32'd1);
    idle_in(); cyc();

    // backpressure with a new request pending
    accept(2'b01);
    dp_out = 1'b1;
    n = 0;
    while (!rsp_valid && n < 40) begin cyc(); n++; end
    req_valid = 1; req_data = 2'b10; dp_out = 1'b0;
    repeat (5) begin
      cyc();
      chk("bp_ready_lit", 32'(req_ready), 32'd0);
      chk("bp_data_lit", 32'(rsp_data), 32'd1);
    end
    rsp_ready = 1; cyc(); rsp_ready = 0;
    chk("bp_hs_ready_lit", 32'(req_ready), 32'd1);
    chk("bp_hs_valid_lit", 32'(rsp_valid), 32'd0);
    cyc();
    chk("bp_next_accept_lit", 32'(req_ready), 32'd0);
    chk("bp_next_op_lit", 32'(dp_in), 32'd2);
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 40) begin cyc(); n++; end
    rsp_ready = 1; cyc(); idle_in();

    // reset two edges into WAIT
    accept(2'b11);
    cyc(); cyc();
    rst_n = 0;
    #1;
    chk("rst_ready_lit", 32'(req_ready), 32'd1);
    chk("rst_valid_lit", 32'(rsp_valid), 32'd0);
    chk("rst_dp_in_lit", 32'(dp_in), 32'd0);
    chk("rst_fatal_lit", 32'(fatal), 32'd0);
    model_reset();
    cyc();
    rst_n = 1;
    saw_rv = 0;
    repeat (10) begin cyc(); if (rsp_valid) saw_rv = 1; end
    chk("rst_no_rsp_lit", 32'(saw_rv), 32'd0);

    // counter saturation
    apply_reset();
    repeat (16) begin
      accept(2'(($urandom)));
      dwc_error = 1;
      n = 0;
      while (!fatal && n < 100) begin cyc(); n++; end
      dwc_error = 0; fatal_clr = 1; cyc(); fatal_clr = 0;
    end
    chk("saturate_lit", 32'(err_count), 32'((2 ** CW) - 1));

    // random traffic
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      req_valid = 1'($urandom);
      req_data  = W'($urandom);
      rsp_ready = 1'($urandom);
      fatal_clr = ($urandom % 6 == 0);
      dwc_error = ($urandom % 5 < 2);
      dp_out    = OW'($urandom);
      if ($urandom % 1500 == 0) apply_reset();
      else cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dwc_retry_ctrl.md
# dwc_retry_ctrl

Transaction controller that sequences a duplicated-with-comparison (DwC) datapath with registered outputs. It accepts one operand at a time, drives it into the DwC datapath, and waits the datapath latency. It then samples the datapath result and comparator error, re-executes on mismatch up to a bounded retry count, and escalates to a sticky fatal state when retries are exhausted.

## Interface
Parameters:
- WIDTH, 2, operand width driven into the datapath
- OUT_WIDTH, 1, datapath result width
- LATENCY, 1, edges from operand stable on port_dp_in to valid port_dp_out/port_dwc_error (range 1-15)
- MAX_RETRY, 3, re-executions allowed after the first mismatch (range 0-7)
- CNT_WIDTH, 8, error event counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- port_req_valid  in  1  request operand valid
- port_req_ready  out  1  controller can accept a request
- port_req_data  in  WIDTH  request operand
- port_dp_in  out  WIDTH  operand to DwC datapath
- port_dp_out  in  OUT_WIDTH  primary replica registered result
- port_dwc_error  in  1  comparator output, 1 = replica mismatch
- port_rsp_valid  out  1  response valid
- port_rsp_ready  in  1  consumer accepts response
- port_rsp_data  out  OUT_WIDTH  checked result
- port_rsp_retries  out  3  retries consumed for this response
- port_fatal  out  1  sticky fatal flag
- port_fatal_clr  in  1  clears the fatal state
- port_err_count  out  CNT_WIDTH  saturating count of mismatch events

## Operation
- States: IDLE, WAIT, CHECK, RESP, FATAL. Reset state is IDLE.
- Reset values: all outputs 0, except port_req_ready = 1. Internal operand, retry and latency counters are 0.
- IDLE: port_req_ready = 1. On valid&ready, load the operand register, clear the retry count, load the latency counter with LATENCY, and go to WAIT.
- port_dp_in always equals the operand register. It is held constant across WAIT, CHECK and all retries.
- WAIT: the latency counter decrements each edge. When the counter is 1, the next state is CHECK.
- CHECK (exactly one cycle): sample port_dwc_error and port_dp_out.
  - No error: latch port_rsp_data = port_dp_out and port_rsp_retries = retry count, then go to RESP.
  - Error and retry < MAX_RETRY: retry+1, err_count+1, reload the latency counter, go to WAIT.
  - Error and retry == MAX_RETRY: err_count+1, go to FATAL. The transaction is dropped and no response is issued.
- RESP: port_rsp_valid = 1. Data and retries are held stable until port_rsp_ready. On valid&ready, go to IDLE.
- FATAL: port_fatal = 1 and port_req_ready = 0. port_fatal_clr sampled high leads to IDLE, with port_fatal = 0 the next cycle.
- port_fatal_clr outside FATAL is ignored.
- port_err_count saturates at 2^CNT_WIDTH-1. Only rst_n clears it.
- Inputs port_dwc_error and port_dp_out are ignored outside CHECK.

## Timing
- Request accepted at edge E0. The operand is on port_dp_in from E0. CHECK occupies the cycle between edges E0+LATENCY and E0+LATENCY+1.
- No-error latency: port_rsp_valid rises after edge E0+LATENCY+1. With LATENCY=1, the response is visible 2 cycles after accept.
- Each retry adds LATENCY+1 cycles.
- Response handshake at edge Er: port_req_ready = 1 from Er. The next request can be accepted at Er+1 at the earliest. There is no same-cycle accept and respond.
- port_req_ready is registered (state-derived). It carries no combinational path from port_rsp_ready.
- rst_n asserted mid-transaction aborts immediately and asynchronously to reset values. The in-flight transaction produces no response.

## Configuration
- DWC_RETRY_CTRL_RETRY_EN
  - Defined: retry behaviour as above, bounded by MAX_RETRY.
  - Undefined: the effective MAX_RETRY is 0. The first mismatch increments port_err_count and enters FATAL. port_rsp_retries is tied to 0.

## Test plan
- Clean pass, LATENCY=1: accept operand 2'b11 at E0, datapath returns 1 with no error. Required: port_rsp_valid after E2, port_rsp_data=1, port_rsp_retries=0, port_err_count=0.
- Single transient: error=1 in the first CHECK only. Required: one retry, response after E0+4, port_rsp_retries=1, port_err_count=1, port_dp_in constant throughout.
- Exhaustion, MAX_RETRY=3: error held at 1. Required: 4 CHECKs, port_err_count=4, port_fatal=1, port_req_ready=0, no port_rsp_valid. Then pulse port_fatal_clr. Required: IDLE, port_fatal=0, port_req_ready=1.
- Backpressure: hold port_rsp_ready=0 for 5 cycles while driving new port_req_valid. Required: response data stable, port_req_ready=0, request not accepted until the cycle after the response handshake.
- Reset mid-WAIT, with LATENCY=4, at cycle 2. Required: all outputs return to reset values immediately, port_req_ready=1 after release, no response issued.
- Macro undefined: first mismatch. Required: FATAL directly, port_err_count=1.
